// File: rtl/sig_frame_streamer_if.sv
// Avalon-ST source bundle carrying one frame packet from the signal-RAM streamer.
interface sig_frame_streamer_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [1:0]  out_empty;

  modport master (output out_data, out_valid, out_sop, out_eop, out_empty, input out_ready);
  modport slave  (input out_data, out_valid, out_sop, out_eop, out_empty, output out_ready);
endinterface

// File: rtl/sig_frame_streamer.sv
// Streams 3 header words, N_CH/2 packed channel pairs and a cluster trailer as one Avalon-ST packet
// per frame; each beat waits RD_LATENCY+1 clocks per RAM read and stalls in SEND while out_ready is low.
module sig_frame_streamer #(
  parameter int N_CH       = 320,
  parameter int HDR_BASE   = 500,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk_clk,
  input  logic        rst_reset,
  input  logic        start,
  input  logic        has_cluster,
  input  logic        no_cluster,
  input  logic [8:0]  ch_left,
  input  logic [8:0]  ch_right,
  output logic [8:0]  sig_rdaddress,
  input  logic [31:0] sig_q,
  sig_frame_streamer_if.master src,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  typedef enum logic [2:0] {IDLE, RD_HDR, RD_LO, RD_HI, SEND, TRAILER} state_t;

  localparam logic [8:0] HDR0    = 9'(HDR_BASE);
  localparam logic [8:0] HDR_END = 9'(HDR_BASE + 2);
  localparam logic [8:0] LAST_HI = 9'(N_CH - 1);
  localparam logic [1:0] LAT     = 2'(RD_LATENCY);

  state_t      state, state_nxt;
  logic [8:0]  addr_nxt;
  logic [1:0]  wait_cnt;
  logic        rd_done;
  logic [15:0] lo_half;
  logic        hc_q, nc_q;
  logic [8:0]  cl_q, cr_q;

  // sig_q is valid after LAT edges past the first cycle holding the new address.
  assign rd_done       = (wait_cnt == LAT);
  assign src.out_valid = (state == SEND);
  assign src.out_empty = 2'b00;

  always_comb begin
    state_nxt = state;
    addr_nxt  = sig_rdaddress;
    case (state)
      IDLE: if (start) begin
        state_nxt = RD_HDR;
        addr_nxt  = HDR0;
      end
      RD_HDR: if (rd_done) state_nxt = SEND;
      RD_LO: if (rd_done) begin
        state_nxt = RD_HI;
        addr_nxt  = sig_rdaddress + 9'd1;
      end
      RD_HI: if (rd_done) state_nxt = SEND;
      SEND: if (src.out_ready) begin
        // The held read address tells which beat just completed (header region lies above channels).
        if (src.out_eop) begin
          state_nxt = IDLE;
        end else if (sig_rdaddress >= HDR0) begin
          if (sig_rdaddress == HDR_END) begin
            state_nxt = RD_LO;
            addr_nxt  = 9'd0;
          end else begin
            state_nxt = RD_HDR;
            addr_nxt  = sig_rdaddress + 9'd1;
          end
        end else if (sig_rdaddress == LAST_HI) begin
          state_nxt = TRAILER;
        end else begin
          state_nxt = RD_LO;
          addr_nxt  = sig_rdaddress + 9'd1;
        end
      end
      TRAILER: state_nxt = SEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge rst_reset) begin
    if (rst_reset) begin
      state         <= IDLE;
      sig_rdaddress <= 9'd0;
      wait_cnt      <= 2'd0;
      lo_half       <= 16'd0;
      src.out_data  <= 32'd0;
      src.out_sop   <= 1'b0;
      src.out_eop   <= 1'b0;
      busy          <= 1'b0;
      overrun_cnt   <= 8'd0;
      hc_q          <= 1'b0;
      nc_q          <= 1'b0;
      cl_q          <= 9'd0;
      cr_q          <= 9'd0;
    end else begin
      state         <= state_nxt;
      sig_rdaddress <= addr_nxt;
      if (state_nxt != state) wait_cnt <= 2'd0;
      else if (!rd_done)      wait_cnt <= wait_cnt + 2'd1;

      if (start && busy && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          hc_q <= has_cluster;
          nc_q <= no_cluster;
          cl_q <= ch_left;
          cr_q <= ch_right;
        end
        RD_HDR: if (rd_done) begin
          src.out_data <= sig_q;
          src.out_sop  <= (sig_rdaddress == HDR0);
          src.out_eop  <= 1'b0;
        end
        RD_LO: if (rd_done) lo_half <= sig_q[15:0];
        RD_HI: if (rd_done) begin
          src.out_data <= {lo_half, sig_q[15:0]};
          src.out_sop  <= 1'b0;
        end
        TRAILER: begin
          src.out_data <= {hc_q, nc_q, 5'b0, cl_q, 7'b0, cr_q};
          src.out_sop  <= 1'b0;
          src.out_eop  <= 1'b1;
        end
        SEND: if (src.out_ready && src.out_eop) busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sig_frame_streamer.sv
// Drives three streamers (RD_LATENCY 1..3) from one RAM image and checks every packet beat.
module tb_sig_frame_streamer;

  logic        clk_clk = 1'b0;
  logic        rst_reset = 1'b1;
  logic [2:0]  start_v = 3'b000;
  logic        has_cluster = 1'b1;
  logic        no_cluster = 1'b0;
  logic [8:0]  ch_left = 9'd37;
  logic [8:0]  ch_right = 9'd41;
  logic        ready = 1'b1;
  int          rdy_mode = 0;
  int          rc = 0;
  logic        clr_log = 1'b0;
  logic [31:0] mem [512];
  int          errors = 0;
  int          checks = 0;

  logic        v_vld [3], v_sop [3], v_eop [3], v_busy [3];
  logic [31:0] v_dat [3], v_q [3];
  logic [7:0]  v_ovr [3];
  logic [8:0]  v_addr [3];
  logic [1:0]  v_emp [3];

  logic [33:0] blog [3][200];
  int          bn [3] = '{0, 0, 0};
  logic        stall_p [3] = '{1'b0, 1'b0, 1'b0};
  logic [33:0] held [3];

  always #5 clk_clk = ~clk_clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sig_frame_streamer_if ifc ();
    logic [31:0] pipe [3];

    assign ifc.out_ready = ready;
    assign v_vld[g] = ifc.out_valid;
    assign v_sop[g] = ifc.out_sop;
    assign v_eop[g] = ifc.out_eop;
    assign v_dat[g] = ifc.out_data;
    assign v_emp[g] = ifc.out_empty;
    assign v_q[g]   = pipe[g];

    always @(posedge clk_clk) begin
      pipe[0] <= mem[v_addr[g]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end

    sig_frame_streamer #(.RD_LATENCY(g + 1)) u_dut (
      .clk_clk       (clk_clk),
      .rst_reset     (rst_reset),
      .start         (start_v[g]),
      .has_cluster   (has_cluster),
      .no_cluster    (no_cluster),
      .ch_left       (ch_left),
      .ch_right      (ch_right),
      .sig_rdaddress (v_addr[g]),
      .sig_q         (v_q[g]),
      .src           (ifc),
      .busy          (v_busy[g]),
      .overrun_cnt   (v_ovr[g])
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk_clk) begin
    #1;
    rc++;
    ready = (rdy_mode == 0) ? 1'b1 : (rc % 4 == 0);
  end

  // Beat logger and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk_clk) begin
    for (int g = 0; g < 3; g++) begin
      if (clr_log) bn[g] = 0;
      if (stall_p[g] && !rst_reset)
        check_eq($sformatf("stall g%0d", g), 64'({v_vld[g], v_sop[g], v_eop[g], v_dat[g]}),
                 64'({1'b1, held[g]}));
      if (v_vld[g] && ready) begin
        if (bn[g] < 200) blog[g][bn[g]] = {v_sop[g], v_eop[g], v_dat[g]};
        bn[g]++;
      end
      stall_p[g] = v_vld[g] && !ready && !rst_reset;
      held[g]    = {v_sop[g], v_eop[g], v_dat[g]};
    end
  end

  function automatic logic [31:0] exp_beat(input int i);
    logic [31:0] a, b;
    if (i < 3) return mem[500 + i];
    if (i < 163) begin
      a = mem[2 * (i - 3)];
      b = mem[2 * (i - 3) + 1];
      return {a[15:0], b[15:0]};
    end
    return {has_cluster, no_cluster, 5'b0, ch_left, 7'b0, ch_right};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic clear_log();
    clr_log = 1'b1;
    @(negedge clk_clk);
    #1;
    clr_log = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] m);
    start_v = m;
    tick();
    start_v = 3'b000;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!v_busy[0] && !v_busy[1] && !v_busy[2]) return;
      tick();
    end
    check_eq({tag, " idle timeout"}, 64'(0), 64'(1));
  endtask

  task automatic check_pkt(input string tag);
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("%s g%0d beats", tag, g), 64'(bn[g]), 64'(164));
      for (int i = 0; i < 164; i++)
        check_eq($sformatf("%s g%0d beat%0d", tag, g, i), 64'(blog[g][i]),
                 64'({i == 0, i == 163, exp_beat(i)}));
    end
  endtask

  initial begin
    bit found;
    for (int a = 0; a < 512; a++) mem[a] = (a < 320) ? 32'(a) : 32'd0;
    mem[500] = 32'hA0000001;
    mem[501] = 32'h00000002;
    mem[502] = 32'h00000003;

    tick(2);
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("rst vld g%0d", g),   64'(v_vld[g]), 64'(0));
      check_eq($sformatf("rst sop g%0d", g),   64'(v_sop[g]), 64'(0));
      check_eq($sformatf("rst eop g%0d", g),   64'(v_eop[g]), 64'(0));
      check_eq($sformatf("rst data g%0d", g),  64'(v_dat[g]), 64'(0));
      check_eq($sformatf("rst busy g%0d", g),  64'(v_busy[g]), 64'(0));
      check_eq($sformatf("rst ovr g%0d", g),   64'(v_ovr[g]), 64'(0));
      check_eq($sformatf("rst addr g%0d", g),  64'(v_addr[g]), 64'(0));
      check_eq($sformatf("rst empty g%0d", g), 64'(v_emp[g]), 64'(0));
    end
    rst_reset = 1'b0;
    tick(3);

    // Full frame at full rate; a start coinciding with the trailer acceptance is an overrun.
    clear_log();
    pulse(3'b111);
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (v_vld[1] && v_eop[1]) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq("s1 trailer seen", 64'(found), 64'(1));
    start_v = 3'b010;
    tick();
    start_v = 3'b000;
    check_eq("s1 busy after trailer", 64'(v_busy[1]), 64'(0));
    check_eq("s1 ovr at trailer", 64'(v_ovr[1]), 64'(1));
    wait_idle("s1", 6000);
    check_pkt("s1");
    check_eq("s1 beat0", 64'(blog[1][0]), 64'({2'b10, 32'hA0000001}));
    check_eq("s1 beat3", 64'(blog[1][3]), 64'({2'b00, 32'h00000001}));
    check_eq("s1 beat162", 64'(blog[1][162]), 64'({2'b00, 32'h013E013F}));
    check_eq("s1 beat163", 64'(blog[1][163]), 64'({2'b01, 32'h80250029}));
    check_eq("s1 ovr g0", 64'(v_ovr[0]), 64'(0));
    check_eq("s1 ovr g2", 64'(v_ovr[2]), 64'(0));

    // Same frame under 1-on/3-off backpressure.
    rdy_mode = 1;
    clear_log();
    pulse(3'b111);
    wait_idle("s2", 8000);
    check_pkt("s2");
    rdy_mode = 0;
    tick(2);

    // Upper half of data words is discarded.
    mem[0] = 32'hFFFF0005;
    mem[1] = 32'h12340006;
    clear_log();
    pulse(3'b111);
    wait_idle("s3", 6000);
    check_pkt("s3");
    for (int g = 0; g < 3; g++)
      check_eq($sformatf("s3 beat3 g%0d", g), 64'(blog[g][3]), 64'({2'b00, 32'h00050006}));
    mem[0] = 32'd0;
    mem[1] = 32'd1;

    // Starts while busy are ignored and counted with saturation.
    clear_log();
    tick(9);
    pulse(3'b111);
    tick(39);
    pulse(3'b111);
    repeat (300) begin
      pulse(3'b111);
      tick();
    end
    for (int g = 0; g < 3; g++)
      check_eq($sformatf("s4 ovr sat g%0d", g), 64'(v_ovr[g]), 64'(255));
    wait_idle("s4", 6000);
    check_pkt("s4");
    clear_log();
    pulse(3'b111);
    wait_idle("s4b", 6000);
    check_pkt("s4b");

    // Reset mid-packet, then a clean packet.
    clear_log();
    pulse(3'b111);
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (bn[1] >= 80) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq("s5 beat80 seen", 64'(found), 64'(1));
    rst_reset = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("s5 rst vld g%0d", g),  64'(v_vld[g]), 64'(0));
      check_eq($sformatf("s5 rst busy g%0d", g), 64'(v_busy[g]), 64'(0));
      check_eq($sformatf("s5 rst ovr g%0d", g),  64'(v_ovr[g]), 64'(0));
    end
    tick();
    rst_reset = 1'b0;
    tick(2);
    clear_log();
    pulse(3'b111);
    wait_idle("s5", 6000);
    check_pkt("s5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sig_frame_streamer.md
Name: sig_frame_streamer

Overview:
- Reader for the per-frame signal RAM (ram4sig) that the reconstruction block fills: 3 header words at addresses 500..502 and 320 background-subtracted 16-bit channels at addresses 0..319, each stored in the low 16 bits.
- Started by the writer's one-cycle frame-complete pulse.
- Reads the RAM through its read port, packs two channels per 32-bit word, appends a cluster trailer word and emits one Avalon-ST packet per frame toward the UDP/readout path.
- The read clock of the RAM is clk_clk.

Parameters:
- N_CH, 320, number of channels read (must be even).
- HDR_BASE, 500, RAM address of the first of 3 header words.
- RD_LATENCY, 2, clocks from sig_rdaddress change to valid sig_q (1..3).

Ports:
- clk_clk  in  1  clock; also drives the RAM rdclock.
- rst_reset  in  1  asynchronous, active-high reset.
- start  in  1  frame-complete pulse (sig_ram_last).
- has_cluster  in  1  cluster flag from the locator; sampled on accepted start.
- no_cluster  in  1  no-cluster flag from the locator; sampled on accepted start.
- ch_left  in  9  cluster left channel; sampled on accepted start.
- ch_right  in  9  cluster right channel; sampled on accepted start.
- sig_rdaddress  out  9  RAM read address (registered).
- sig_q  in  32  RAM read data.
- out_data  out  32  Avalon-ST source data.
- out_valid  out  1  source valid.
- out_ready  in  1  sink ready.
- out_sop  out  1  start of packet.
- out_eop  out  1  end of packet.
- out_empty  out  2  constant 0.
- busy  out  1  high from accepted start until the trailer beat is accepted.
- overrun_cnt  out  8  saturating count of starts ignored while busy.

Behaviour:
- Reset values: state IDLE; sig_rdaddress 0; out_data 0; out_valid 0; out_sop 0; out_eop 0; busy 0; overrun_cnt 0; latched cluster fields 0.
- Read timing rule: in a read state, sig_rdaddress is loaded on entry. sig_q is captured at the RD_LATENCY-th clock edge after the first cycle in which sig_rdaddress holds the new address; a wait counter enforces this.
- Packet format, 3 + N_CH/2 + 1 beats (164 at default):
  - beats 0..2: RAM[HDR_BASE..HDR_BASE+2] verbatim; out_sop on beat 0 only.
  - beat 3+k (k = 0..N_CH/2-1): {RAM[2k][15:0], RAM[2k+1][15:0]}.
  - last beat: {has_cluster, no_cluster, 5'b0, ch_left, 7'b0, ch_right}, using the latched values; out_eop on this beat only.
- State machine:
  - IDLE:
    - start=1 → latch cluster inputs, busy=1, beat index 0, go RD_HDR.
  - RD_HDR:
    - address HDR_BASE + index; after the latency, capture into out_data, go SEND.
  - RD_LO:
    - address 2k; after the latency, hold sig_q[15:0] in the upper half-register, go RD_HI.
  - RD_HI:
    - address 2k+1; after the latency, out_data = {lo, sig_q[15:0]}, go SEND.
  - SEND:
    - out_valid=1. Beat completes on out_valid & out_ready.
    - Next state after completion: header index < 2 → RD_HDR; header done or k < N_CH/2-1 → RD_LO; last data word → TRAILER; trailer complete → IDLE (busy=0 the same edge).
  - TRAILER:
    - load the trailer word into out_data in one cycle, go SEND.
- Handshake rules:
  - out_data, out_sop and out_eop stay stable while out_valid & !out_ready.
  - out_valid never deasserts without acceptance.
  - out_valid is 0 in all states except SEND.
  - out_ready is ignored outside SEND; RAM reads proceed regardless of out_ready.
- Arithmetic and widths:
  - Only the low 16 bits of data-word RAM reads are used; the upper 16 bits are discarded.
  - Addresses are 9-bit and never exceed 511.
  - The channel address never reaches N_CH.
- Boundary conditions:
  - start while busy: ignored, packet in progress unaffected, overrun_cnt += 1, saturating at 255.
  - start on the same edge that the trailer is accepted: busy is still 1, so the start counts as an overrun.
  - Reset mid-packet: immediate return to reset values. No eop is emitted; the downstream sink must tolerate a truncated packet.
  - out_ready held low indefinitely: the block stalls in SEND with no timeout.

Test Plan:
- RAM[500..502]=0xA0000001/0x00000002/0x00000003, RAM[c]=c for c=0..319, ready=1, has_cluster=1, ch_left=37, ch_right=41, then one start pulse → exactly 164 beats. Beat0=0xA0000001 with sop. Beat3=0x00000001. Beat162=0x013E013F. Beat163=0x80250029 with eop.
- Same frame with out_ready toggling 1 cycle on / 3 off → identical beat sequence; data, sop and eop stable during every stall; no beat dropped or duplicated.
- RAM[0] upper half=0xFFFF, RAM[0]=0xFFFF0005, RAM[1]=0x12340006 → beat3=0x00050006.
- start pulses at cycles 10 and 50, then 300 extra pulses while busy → one packet; overrun_cnt=255 (saturated); next start after busy=0 gives a new packet.
- Assert rst_reset at beat 80 → out_valid=0, busy=0, overrun_cnt=0 immediately. Next start gives a complete 164-beat packet from beat 0.
- RD_LATENCY=1 and RD_LATENCY=3 builds with the RAM model of matching latency → beat contents identical to scenario 1.
